ashl4_seq: RTL

- Sequential arithmetic LEFT shifter: the opposite direction to the ALU's arithmetic-right-shift datapath.
- Shifts a signed WIDTH-bit operand left by a programmable amount, one bit position per clock.
- Flags signed overflow: any step where the sign bit changes.
- Uses a start/busy/done handshake. Sits beside the combinational shift units as the multi-cycle shift path of the integer ALU.

---
 rtl/ashl4_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/ashl4_seq.sv
// rtl/ashl4_seq.sv - sequential arithmetic left shifter, one bit per clock, with signed-overflow flag
//
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset; aborts any operation in flight
//   start : request a shift; a and shamt are captured on the same edge
//   a     : signed WIDTH-bit operand
//   shamt : shift amount, 0..2^SHW-1 (amounts of WIDTH or more give y=0)
//   y     : working/result register; final only while done=1 and until the next start
//   ovf   : sticky signed-overflow flag for the current operation
//   busy  : high while shifting
//   done  : one-cycle pulse marking y and ovf as final
module ashl4_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start exactly like IDLE, so held start gives
        // back-to-back operations with no idle cycle in between.
        if (start) begin
          y_d     = a;
          cnt_d   = shamt;
          ovf_d   = 1'b0;
          state_d = (shamt != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // A sign change on any single step means the true product no longer
        // fits; the flag is sticky so it survives later steps that shift
        // the offending bits out.
        y_d   = {y_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | (y_q[WIDTH-1] ^ y_q[WIDTH-2]);
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign y    = y_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule
